// File: rtl/sha_msg_streamer.sv
// Message-to-core sequencer: latches a candidate message, clears the SHA core,
// streams the bytes over a valid/ack handshake, strobes stop and captures the
// digest (or flags a timeout if the core never answers).
module sha_msg_streamer #(
    parameter int unsigned MAX_BYTES  = 32,
    parameter int unsigned LEN_W      = 6,
    parameter int unsigned DIGEST_W   = 256,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*MAX_BYTES-1:0] msg_data,
    input  logic [LEN_W-1:0]       msg_len,
    input  logic                   msb_first,
    output logic                   core_rst_n,
    output logic                   byte_rdy,
    output logic [7:0]             data_in,
    input  logic                   byte_ack,
    output logic                   byte_stop,
    input  logic                   hash_valid,
    input  logic [DIGEST_W-1:0]    hash_in,
    output logic [DIGEST_W-1:0]    digest,
    output logic                   busy,
    output logic                   done,
    output logic                   len_err,
    output logic                   timeout_err
);

    localparam int unsigned CLR_W  = $clog2(CLR_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StClr, StSend, StStop, StWait} state_e;

    state_e                 state_q, state_d;
    logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [LEN_W-1:0]       sent_q, sent_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [8*MAX_BYTES-1:0] msg_q, msg_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   msb_q, msb_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   byte_rdy_q, byte_rdy_d;
    logic [7:0]             data_in_q;
    logic                   byte_stop_q, byte_stop_d;
    logic [DIGEST_W-1:0]    digest_q, digest_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   len_err_q, len_err_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   load_byte;
    logic [LEN_W-1:0]       sel;
    logic [7:0]             next_byte;

    // Next-state and registered-output decode for the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        sent_d        = sent_q;
        wait_cnt_d    = wait_cnt_q;
        msg_d         = msg_q;
        len_d         = len_q;
        msb_d         = msb_q;
        core_rst_n_d  = core_rst_n_q;
        byte_rdy_d    = byte_rdy_q;
        load_byte     = 1'b0;
        byte_stop_d   = 1'b0;
        digest_d      = digest_q;
        done_d        = 1'b0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                core_rst_n_d = 1'b0;
                byte_rdy_d   = 1'b0;
                if (start) begin
                    if (msg_len > LEN_W'(MAX_BYTES)) begin
                        len_err_d = 1'b1;
                    end else begin
                        msg_d     = msg_data;
                        len_d     = msg_len;
                        msb_d     = msb_first;
                        clr_cnt_d = '0;
                        state_d   = StClr;
                    end
                end
            end
            StClr: begin
                if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                    core_rst_n_d = 1'b1;
                    sent_d       = '0;
                    if (len_q == '0) begin
                        state_d     = StStop;
                        byte_stop_d = 1'b1;
                    end else begin
                        state_d    = StSend;
                        byte_rdy_d = 1'b1;
                        load_byte  = 1'b1;
                    end
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            StSend: begin
                if (byte_ack) begin
                    sent_d = sent_q + LEN_W'(1);
                    if (sent_q + LEN_W'(1) == len_q) begin
                        state_d     = StStop;
                        byte_rdy_d  = 1'b0;
                        byte_stop_d = 1'b1;
                    end else begin
                        load_byte = 1'b1;
                    end
                end
            end
            StStop: begin
                // The stop cycle itself counts as the first elapsed cycle.
                state_d    = StWait;
                wait_cnt_d = WAIT_W'(1);
            end
            StWait: begin
                if (hash_valid) begin
                    digest_d = hash_in;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else if (wait_cnt_q >= WAIT_W'(TIMEOUT - 1)) begin
                    done_d        = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // Select the byte addressed by the next sent-count in the latched order.
    always_comb begin
        sel       = msb_q ? (len_q - LEN_W'(1) - sent_d) : sent_d;
        next_byte = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (sel == LEN_W'(k)) next_byte = msg_q[8*k +: 8];
        end
    end

    // State, counters, latched message and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            clr_cnt_q     <= '0;
            sent_q        <= '0;
            wait_cnt_q    <= '0;
            msg_q         <= '0;
            len_q         <= '0;
            msb_q         <= 1'b0;
            core_rst_n_q  <= 1'b0;
            byte_rdy_q    <= 1'b0;
            data_in_q     <= '0;
            byte_stop_q   <= 1'b0;
            digest_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            sent_q        <= sent_d;
            wait_cnt_q    <= wait_cnt_d;
            msg_q         <= msg_d;
            len_q         <= len_d;
            msb_q         <= msb_d;
            core_rst_n_q  <= core_rst_n_d;
            byte_rdy_q    <= byte_rdy_d;
            data_in_q     <= load_byte ? next_byte : data_in_q;
            byte_stop_q   <= byte_stop_d;
            digest_q      <= digest_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign byte_rdy    = byte_rdy_q;
    assign data_in     = data_in_q;
    assign byte_stop   = byte_stop_q;
    assign digest      = digest_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign len_err     = len_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sha_msg_streamer.sv
// Self-checking bench for sha_msg_streamer: table of message transactions with a
// byte scoreboard, plus hand-written length-error and mid-stream reset sequences.
module tb_sha_msg_streamer;

    localparam int MAXB    = 32;
    localparam int LW      = 6;
    localparam int DW      = 256;
    localparam int CLRC    = 2;
    localparam int TMO     = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [8*MAXB-1:0] msg_data;
    logic [LW-1:0]   msg_len;
    logic            msb_first;
    logic            core_rst_n;
    logic            byte_rdy;
    logic [7:0]      data_in;
    logic            byte_ack;
    logic            byte_stop;
    logic            hash_valid;
    logic [DW-1:0]   hash_in;
    logic [DW-1:0]   digest;
    logic            busy;
    logic            done;
    logic            len_err;
    logic            timeout_err;

    sha_msg_streamer #(
        .MAX_BYTES (MAXB),
        .LEN_W     (LW),
        .DIGEST_W  (DW),
        .CLR_CYCLES(CLRC),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .msg_data   (msg_data),
        .msg_len    (msg_len),
        .msb_first  (msb_first),
        .core_rst_n (core_rst_n),
        .byte_rdy   (byte_rdy),
        .data_in    (data_in),
        .byte_ack   (byte_ack),
        .byte_stop  (byte_stop),
        .hash_valid (hash_valid),
        .hash_in    (hash_in),
        .digest     (digest),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        bit         msb;
        int         ack_mode;   // 0: always 1, 1: toggle 1,0,.., 2: random
        int         lat;        // WAIT cycles before hash_valid, -1 = never
        logic [DW-1:0] hval;
        logic [7:0] xr;         // byte k of the message is k ^ xr
        bit         early_hv;   // junk hash_valid during the stop cycle
        bit         start_in_wait;
    } vec_t;

    vec_t          vecs[7];
    logic [7:0]    exp_q[$];
    logic [DW-1:0] exp_digest;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_msg(input logic [7:0] xr);
        for (int k = 0; k < MAXB; k++) msg_data[8*k +: 8] = 8'(k) ^ xr;
    endtask

    task automatic check_reset_vals();
        check("rst core_rst_n", core_rst_n, 0);
        check("rst byte_rdy", byte_rdy, 0);
        check("rst data_in", data_in, 0);
        check("rst byte_stop", byte_stop, 0);
        check("rst digest", digest, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst len_err", len_err, 0);
        check("rst timeout_err", timeout_err, 0);
    endtask

    // One full transaction: start, clear, stream via scoreboard, stop, digest wait.
    task automatic run_msg(input vec_t v);
        int   s_cyc, xfers, exp_done, guard;
        bit   ack, tog, held, got, hv_ok;
        logic [7:0] prev, e;
        set_msg(v.xr);
        exp_q.delete();
        for (int i = 0; i < v.len; i++) begin
            int k = v.msb ? v.len - 1 - i : i;
            exp_q.push_back(8'(k) ^ v.xr);
        end
        msg_len = LW'(v.len);
        msb_first = v.msb;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        check("clr busy", busy, 1);
        check("clr core_rst_n c1", core_rst_n, 0);
        tick();
        check("clr core_rst_n c2", core_rst_n, 0);
        check("clr byte_rdy", byte_rdy, 0);
        tick();
        check("core_rst_n released", core_rst_n, 1);
        if (v.len == 0) check("len0 stop at T+3", byte_stop, 1);
        else check("first byte_rdy at T+3", byte_rdy, 1);
        xfers = 0;
        tog = 1'b1;
        held = 1'b0;
        prev = '0;
        guard = 0;
        while (!byte_stop && guard < 400) begin
            case (v.ack_mode)
                0: ack = 1'b1;
                1: ack = tog;
                default: ack = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            byte_ack = ack;
            if (held) check("byte held stable", data_in, prev);
            if (byte_rdy && ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected extra byte", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_in", data_in, e);
                end
                xfers++;
            end
            held = byte_rdy && !ack;
            prev = data_in;
            tick();
            guard++;
        end
        check("byte_stop reached", byte_stop, 1);
        check("transfer count", xfers, v.len);
        check("scoreboard empty", exp_q.size(), 0);
        check("byte_rdy low at stop", byte_rdy, 0);
        if (v.ack_mode == 0) check("stop cycle", cyc, 3 + v.len);
        s_cyc = cyc;
        byte_ack = 1'b0;
        hash_valid = v.early_hv;
        hash_in = {(DW/8){8'hEE}};
        tick();
        hash_valid = 1'b0;
        check("byte_stop one cycle", byte_stop, 0);
        if (v.start_in_wait) begin
            start = 1'b1;
            msg_len = LW'(4);
        end
        hv_ok = (v.lat >= 0) && (v.lat <= TMO - 2);
        exp_done = hv_ok ? s_cyc + 2 + v.lat : s_cyc + TMO;
        got = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (v.lat >= 0 && cyc == s_cyc + 1 + v.lat) begin
                hash_valid = 1'b1;
                hash_in = v.hval;
            end else begin
                hash_valid = 1'b0;
                hash_in = {(DW/8){8'h55}};
            end
            tick();
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        hash_valid = 1'b0;
        if (hv_ok) exp_digest = v.hval;
        check("done seen", got, 1);
        check("done cycle", cyc, exp_done);
        check("timeout_err", timeout_err, !hv_ok);
        check("digest", digest, exp_digest);
        tick();
        check("done one cycle", done, 0);
        check("timeout_err one cycle", timeout_err, 0);
        check("idle after done", busy, 0);
        check("core_rst_n low in idle", core_rst_n, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        vec_t r;
        vecs[0] = '{len: 3,  msb: 1'b1, ack_mode: 0, lat: 0,  hval: {32{8'hAB}},
                    xr: 8'h00, early_hv: 1'b0, start_in_wait: 1'b0};
        vecs[1] = '{len: 32, msb: 1'b0, ack_mode: 1, lat: 2,  hval: {8{32'h1234_5678}},
                    xr: 8'h00, early_hv: 1'b0, start_in_wait: 1'b0};
        vecs[2] = '{len: 0,  msb: 1'b0, ack_mode: 0, lat: 1,  hval: {16{16'hC0DE}},
                    xr: 8'h00, early_hv: 1'b0, start_in_wait: 1'b0};
        vecs[3] = '{len: 7,  msb: 1'b1, ack_mode: 2, lat: TMO - 2, hval: {4{64'h0123_4567_89AB_CDEF}},
                    xr: 8'h5A, early_hv: 1'b0, start_in_wait: 1'b0};
        vecs[4] = '{len: 5,  msb: 1'b0, ack_mode: 0, lat: -1, hval: {32{8'h11}},
                    xr: 8'h00, early_hv: 1'b1, start_in_wait: 1'b0};
        vecs[5] = '{len: 1,  msb: 1'b1, ack_mode: 0, lat: 3,  hval: {32{8'h3C}},
                    xr: 8'hC3, early_hv: 1'b0, start_in_wait: 1'b0};
        vecs[6] = '{len: 32, msb: 1'b1, ack_mode: 2, lat: 0,  hval: {32{8'h96}},
                    xr: 8'hFF, early_hv: 1'b0, start_in_wait: 1'b1};

        reset = 1'b0;
        start = 1'b0;
        msg_data = '0;
        msg_len = '0;
        msb_first = 1'b0;
        byte_ack = 1'b0;
        hash_valid = 1'b0;
        hash_in = '0;
        exp_digest = '0;
        tick();
        tick();
        check_reset_vals();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_msg(vecs[i]);

        // Over-length request: error pulse only, nothing latched, core held in reset.
        set_msg(8'h00);
        msg_len = LW'(33);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len_err pulse", len_err, 1);
        check("len_err busy", busy, 0);
        check("len_err core_rst_n", core_rst_n, 0);
        tick();
        check("len_err one cycle", len_err, 0);
        check("len_err still idle", busy, 0);
        r = '{len: 5, msb: 1'b1, ack_mode: 0, lat: 1, hval: {32{8'h77}},
              xr: 8'h00, early_hv: 1'b0, start_in_wait: 1'b0};
        run_msg(r);

        // Reset after two of ten bytes, then a clean restart from the first byte.
        set_msg(8'h00);
        msg_len = LW'(10);
        msb_first = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        byte_ack = 1'b1;
        check("pre-reset byte0", data_in, 8'h00);
        tick();
        check("pre-reset byte1", data_in, 8'h01);
        tick();
        check("pre-reset byte2 shown", data_in, 8'h02);
        reset = 1'b0;
        tick();
        byte_ack = 1'b0;
        exp_digest = '0;
        check_reset_vals();
        reset = 1'b1;
        tick();
        check("post-reset idle", busy, 0);
        r = '{len: 10, msb: 1'b0, ack_mode: 0, lat: 4, hval: {32{8'h42}},
              xr: 8'h00, early_hv: 1'b0, start_in_wait: 1'b1};
        run_msg(r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
